// File: rtl/lvds_rx_align_if.sv
// rtl/lvds_rx_align_if.sv - raw word input and aligned byte output bundle for lvds_rx_align
interface lvds_rx_align_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       resync;
  logic [7:0] data_out;
  logic       data_valid;
  logic       locked;
  logic [2:0] offset;
  logic       lock_lost;

  modport master (
    output rx_data, rx_valid, resync,
    input  data_out, data_valid, locked, offset, lock_lost
  );

  modport slave (
    input  rx_data, rx_valid, resync,
    output data_out, data_valid, locked, offset, lock_lost
  );
endinterface

// File: rtl/lvds_rx_align.sv
// rtl/lvds_rx_align.sv - training-pattern word aligner with barrel shifter; optional LVDS_ALIGN_STRIP_SYNC_EN drops training words once locked
module lvds_rx_align #(
  parameter logic [7:0] SYNC_PATTERN = 8'hA5,
  parameter int         LOCK_COUNT   = 4
) (
  input  logic           clk,
  input  logic           rst,
  lvds_rx_align_if.slave bus
);

  localparam int            CW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] LC = CW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t        r_state, w_state_nx;
  logic [7:0]    r_prev;
  logic          r_prev_ok;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [CW-1:0] r_miss, w_miss_nx;
  logic [2:0]    r_cand, w_cand_nx;
  logic [2:0]    r_offset, w_offset_nx;
  logic [7:0]    r_data_out, w_data_out_nx;
  logic          r_data_valid, w_data_valid_nx;
  logic          r_lock_lost, w_lock_lost_nx;

  logic [15:0]   w_win;
  logic [7:0]    w_match;
  logic          w_hit;
  logic [2:0]    w_hit_off;
  logic          w_match_off;
  logic          w_match_other;
  logic [7:0]    w_aligned;

  assign w_win         = {r_prev, bus.rx_data};
  assign w_aligned     = w_win[{1'b0, r_offset} +: 8];
  assign w_match_off   = w_match[r_offset];
  assign w_match_other = |(w_match & ~(8'b1 << r_offset));

  // Compare every rotation of the two-word window and pick the lowest matching offset
  always_comb begin
    w_match   = '0;
    w_hit     = 1'b0;
    w_hit_off = '0;
    for (int k = 0; k < 8; k++) begin
      w_match[k] = bus.rx_valid && r_prev_ok && (w_win[k +: 8] == SYNC_PATTERN);
    end
    for (int k = 7; k >= 0; k--) begin
      if (w_match[k]) begin
        w_hit     = 1'b1;
        w_hit_off = 3'(k);
      end
    end
  end

  // Previous-word register; only accepted words shift into the window
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= '0;
      r_prev_ok <= 1'b0;
    end else if (bus.rx_valid) begin
      r_prev    <= bus.rx_data;
      r_prev_ok <= 1'b1;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_HUNT;
      r_cnt        <= '0;
      r_miss       <= '0;
      r_cand       <= '0;
      r_offset     <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_miss       <= w_miss_nx;
      r_cand       <= w_cand_nx;
      r_offset     <= w_offset_nx;
      r_data_out   <= w_data_out_nx;
      r_data_valid <= w_data_valid_nx;
      r_lock_lost  <= w_lock_lost_nx;
    end
  end

  // Hunt / verify / locked transitions; resync overrides everything and never reports loss
  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_miss_nx       = r_miss;
    w_cand_nx       = r_cand;
    w_offset_nx     = r_offset;
    w_data_out_nx   = r_data_out;
    w_data_valid_nx = 1'b0;
    w_lock_lost_nx  = 1'b0;
    if (bus.resync) begin
      w_state_nx = S_HUNT;
      w_cnt_nx   = '0;
      w_miss_nx  = '0;
    end else if (bus.rx_valid) begin
      case (r_state)
        S_HUNT: begin
          if (w_hit) begin
            w_cand_nx = w_hit_off;
            w_cnt_nx  = CW'(1);
            if (LC == CW'(1)) begin
              w_offset_nx = w_hit_off;
              w_state_nx  = S_LOCKED;
            end else begin
              w_state_nx  = S_VERIFY;
            end
          end
        end
        S_VERIFY: begin
          if (w_match[r_cand]) begin
            w_cnt_nx = (r_cnt < LC) ? r_cnt + 1'b1 : r_cnt;
            if (r_cnt >= LC - 1'b1) begin
              w_offset_nx = r_cand;
              w_miss_nx   = '0;
              w_state_nx  = S_LOCKED;
            end
          end else begin
            w_cnt_nx   = '0;
            w_state_nx = S_HUNT;
          end
        end
        S_LOCKED: begin
          w_data_out_nx = w_aligned;
`ifdef LVDS_ALIGN_STRIP_SYNC_EN
          w_data_valid_nx = !w_match_off;
`else
          w_data_valid_nx = 1'b1;
`endif
          if (w_match_other) begin
            w_miss_nx = (r_miss < LC) ? r_miss + 1'b1 : r_miss;
            if (r_miss >= LC - 1'b1) begin
              w_lock_lost_nx = 1'b1;
              w_cnt_nx       = '0;
              w_miss_nx      = '0;
              w_state_nx     = S_HUNT;
            end
          end else begin
            w_miss_nx = '0;
          end
        end
        default: begin
          w_cnt_nx   = '0;
          w_miss_nx  = '0;
          w_state_nx = S_HUNT;
        end
      endcase
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.locked     = (r_state == S_LOCKED);
  assign bus.offset     = r_offset;
  assign bus.lock_lost  = r_lock_lost;

endmodule
